// File: rtl/hms_pkg.sv
// Shared types, field limits and BCD helpers for the HH:MM:SS time-set controller.
package hms_pkg;

   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_SET_H  = 3'd1,
      ST_SET_M  = 3'd2,
      ST_SET_S  = 3'd3,
      ST_COMMIT = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      FLD_NONE = 2'd0,
      FLD_HOUR = 2'd1,
      FLD_MIN  = 2'd2,
      FLD_SEC  = 2'd3
   } field_t;

   localparam logic [7:0] HOUR_MAX = 8'd23;
   localparam logic [7:0] MIN_MAX  = 8'd59;

   // Binary 0..99 to two BCD digits; anything above 99 becomes 0.
   function automatic logic [7:0] bin2bcd8(input logic [7:0] bin);
      logic [7:0] tens;
      logic [7:0] units;
      if (bin > 8'd99) return '0;
      tens  = bin / 8'd10;
      units = bin % 8'd10;
      return {tens[3:0], units[3:0]};
   endfunction

   // Two BCD digits to binary; a non-BCD digit or a value above max becomes 0.
   function automatic logic [7:0] bcd2bin8(input logic [7:0] bcd, input logic [7:0] max);
      logic [7:0] val;
      if ((bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9)) return '0;
      val = ({4'd0, bcd[7:4]} * 8'd10) + {4'd0, bcd[3:0]};
      return (val > max) ? '0 : val;
   endfunction

   // One up/down step with wrap-around between 0 and max.
   function automatic logic [7:0] wrap_step(input logic [7:0] val, input logic up,
                                            input logic [7:0] max);
      if (up) return (val == max) ? '0 : val + 8'd1;
      return (val == '0) ? max : val - 8'd1;
   endfunction

endpackage

// File: rtl/hms_tick_div.sv
// Terminal-count counter: tc is high for the one cycle the count sits at TC-1 while enabled.
module hms_tick_div #(
   parameter longint unsigned TC = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned    W    = (TC > 1) ? $clog2(TC) : 1;
   localparam logic [W-1:0]   LAST = W'(TC - 1);

   logic [W-1:0] r_cnt;

   assign tc = en && (r_cnt == LAST);

   // Count enabled cycles, wrapping at the terminal count; clr restarts from zero.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= tc ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hms_set_ctrl.sv
// Time-set controller: pauses the timekeeper, edits H/M/S with buttons, loads the result back
// and drives per-digit blink blanking for the field under edit.
module hms_set_ctrl
   import hms_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned BLINK_HZ  = 2,
   parameter int unsigned TIMEOUT_S = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cur_hms,
   input  logic        btn_mode,
   input  logic        btn_up,
   input  logic        btn_down,
   output logic        run_en,
   output logic        load,
   output logic [31:0] load_hms,
   output logic [1:0]  edit_field,
   output logic [7:0]  blank_mask
);

   localparam longint unsigned BLINK_TC = 64'(CLK_HZ) / (64'(BLINK_HZ) * 64'd2);
   localparam longint unsigned IDLE_TC  = 64'(CLK_HZ) * 64'(TIMEOUT_S);

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_h, r_m, r_s, w_h_nxt, w_m_nxt, w_s_nxt;
   logic        r_phase, w_phase_nxt;
   logic        r_run_en, w_run_en_nxt;
   logic        r_load, w_load_nxt;
   logic [31:0] r_load_hms, w_load_hms_nxt;
   field_t      r_edit_field, w_edit_field_nxt;
   logic [7:0]  r_blank, w_blank_nxt;

   logic w_in_set, w_any_btn, w_edit, w_timeout, w_changed;
   logic w_blink_clr, w_blink_tc, w_idle_clr, w_idle_tc;

   assign w_in_set    = (r_state == ST_SET_H) || (r_state == ST_SET_M) || (r_state == ST_SET_S);
   assign w_any_btn   = btn_mode | btn_up | btn_down;
   assign w_edit      = w_in_set & ~btn_mode & (btn_up ^ btn_down);
   assign w_timeout   = w_in_set & ~w_any_btn & w_idle_tc;
   assign w_changed   = (w_state_nxt != r_state);
   assign w_blink_clr = w_changed | w_edit | ~w_in_set;
   assign w_idle_clr  = w_changed | w_any_btn | ~w_in_set;

   hms_tick_div #(.TC(BLINK_TC)) u_blink (
      .clk (clk),
      .rst (rst),
      .clr (w_blink_clr),
      .en  (w_in_set),
      .tc  (w_blink_tc)
   );

   generate
      if (IDLE_TC > 0) begin : g_idle
         hms_tick_div #(.TC(IDLE_TC)) u_idle (
            .clk (clk),
            .rst (rst),
            .clr (w_idle_clr),
            .en  (w_in_set),
            .tc  (w_idle_tc)
         );
      end else begin : g_no_idle
         assign w_idle_tc = 1'b0;
      end
   endgenerate

   // Next state and edit registers: mode advances, a lone up/down edits, idle timeout aborts.
   always_comb begin
      w_state_nxt = r_state;
      w_h_nxt     = r_h;
      w_m_nxt     = r_m;
      w_s_nxt     = r_s;
      case (r_state)
         ST_RUN: begin
            if (btn_mode) begin
               w_h_nxt     = bcd2bin8(cur_hms[23:16], HOUR_MAX);
               w_m_nxt     = bcd2bin8(cur_hms[15:8],  MIN_MAX);
               w_s_nxt     = bcd2bin8(cur_hms[7:0],   MIN_MAX);
               w_state_nxt = ST_SET_H;
            end
         end
         ST_SET_H: begin
            if (btn_mode)       w_state_nxt = ST_SET_M;
            else if (w_edit)    w_h_nxt     = wrap_step(r_h, btn_up, HOUR_MAX);
            else if (w_timeout) w_state_nxt = ST_RUN;
         end
         ST_SET_M: begin
            if (btn_mode)       w_state_nxt = ST_SET_S;
            else if (w_edit)    w_m_nxt     = wrap_step(r_m, btn_up, MIN_MAX);
            else if (w_timeout) w_state_nxt = ST_RUN;
         end
         ST_SET_S: begin
            if (btn_mode)       w_state_nxt = ST_COMMIT;
            else if (w_edit)    w_s_nxt     = wrap_step(r_s, btn_up, MIN_MAX);
            else if (w_timeout) w_state_nxt = ST_RUN;
         end
         ST_COMMIT: w_state_nxt = ST_RUN;
         default:   w_state_nxt = ST_RUN;
      endcase
   end

   // Output values derived from the upcoming state so every output is a plain register.
   always_comb begin
      w_run_en_nxt   = (w_state_nxt == ST_RUN);
      w_load_nxt     = (w_state_nxt == ST_COMMIT);
      w_load_hms_nxt = r_load_hms;
      if (w_load_nxt) begin
         w_load_hms_nxt = {8'h00, bin2bcd8(w_h_nxt), bin2bcd8(w_m_nxt), bin2bcd8(w_s_nxt)};
      end
      w_phase_nxt = r_phase;
      if (w_blink_clr)     w_phase_nxt = 1'b0;
      else if (w_blink_tc) w_phase_nxt = ~r_phase;
      w_edit_field_nxt = FLD_NONE;
      w_blank_nxt      = '0;
      case (w_state_nxt)
         ST_SET_H: begin
            w_edit_field_nxt = FLD_HOUR;
            if (w_phase_nxt) w_blank_nxt = 8'h30;
         end
         ST_SET_M: begin
            w_edit_field_nxt = FLD_MIN;
            if (w_phase_nxt) w_blank_nxt = 8'h0C;
         end
         ST_SET_S: begin
            w_edit_field_nxt = FLD_SEC;
            if (w_phase_nxt) w_blank_nxt = 8'h03;
         end
         default: ;
      endcase
   end

   // State, edit registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_RUN;
         r_h          <= '0;
         r_m          <= '0;
         r_s          <= '0;
         r_phase      <= 1'b0;
         r_run_en     <= 1'b1;
         r_load       <= 1'b0;
         r_load_hms   <= '0;
         r_edit_field <= FLD_NONE;
         r_blank      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_h          <= w_h_nxt;
         r_m          <= w_m_nxt;
         r_s          <= w_s_nxt;
         r_phase      <= w_phase_nxt;
         r_run_en     <= w_run_en_nxt;
         r_load       <= w_load_nxt;
         r_load_hms   <= w_load_hms_nxt;
         r_edit_field <= w_edit_field_nxt;
         r_blank      <= w_blank_nxt;
      end
   end

   assign run_en     = r_run_en;
   assign load       = r_load;
   assign load_hms   = r_load_hms;
   assign edit_field = r_edit_field;
   assign blank_mask = r_blank;

endmodule

// File: tb/tb_hms_set_ctrl.sv
// Bench for hms_set_ctrl: directed scenarios with literal expectations plus randomized
// stimulus, all outputs compared every cycle against a behavioural model.
module tb_hms_set_ctrl;

   localparam int unsigned CLK_HZ     = 40;
   localparam int unsigned BLINK_HZ   = 2;
   localparam int unsigned TIMEOUT_S  = 2;
   localparam int          BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int          IDLE_LIMIT = CLK_HZ * TIMEOUT_S;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cur_hms = '0;
   logic        btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic        run_en, load;
   logic [31:0] load_hms;
   logic [1:0]  edit_field;
   logic [7:0]  blank_mask;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hms_set_ctrl #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .TIMEOUT_S(TIMEOUT_S)) dut (
      .clk        (clk),
      .rst        (rst),
      .cur_hms    (cur_hms),
      .btn_mode   (btn_mode),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .run_en     (run_en),
      .load       (load),
      .load_hms   (load_hms),
      .edit_field (edit_field),
      .blank_mask (blank_mask)
   );

   // Model: m_fld 0 = running, 1..3 = editing hour/min/sec, 4 = loading.
   int          m_fld = 0;
   int          m_val [1:3];
   int          m_elapsed = 0;
   int          m_idle = 0;
   logic [31:0] m_load_hms = '0;

   function automatic int fmax(input int f);
      return (f == 1) ? 23 : 59;
   endfunction

   function automatic int cap(input logic [7:0] b, input int max);
      int hi, lo, v;
      hi = int'(b[7:4]);
      lo = int'(b[3:0]);
      if (hi > 9 || lo > 9) return 0;
      v = hi * 10 + lo;
      return (v > max) ? 0 : v;
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   function automatic logic [7:0] exp_blank();
      if (m_fld < 1 || m_fld > 3) return 8'h00;
      if (((m_elapsed / BLINK_HALF) % 2) == 0) return 8'h00;
      return 8'h03 << (2 * (3 - m_fld));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin : model
      int nf;
      bit edited;
      bit any;
      if (rst) begin
         m_fld = 0;
         for (int i = 1; i <= 3; i++) m_val[i] = 0;
         m_elapsed  = 0;
         m_idle     = 0;
         m_load_hms = '0;
      end else begin
         nf     = m_fld;
         edited = 1'b0;
         any    = btn_mode | btn_up | btn_down;
         if (m_fld == 4) begin
            nf = 0;
         end else if (m_fld == 0) begin
            if (btn_mode) begin
               m_val[1] = cap(cur_hms[23:16], 23);
               m_val[2] = cap(cur_hms[15:8], 59);
               m_val[3] = cap(cur_hms[7:0], 59);
               nf = 1;
            end
         end else begin
            if (btn_mode) begin
               nf = m_fld + 1;
            end else if (btn_up != btn_down) begin
               edited = 1'b1;
               if (btn_up) m_val[m_fld] = (m_val[m_fld] + 1) % (fmax(m_fld) + 1);
               else m_val[m_fld] = (m_val[m_fld] + fmax(m_fld)) % (fmax(m_fld) + 1);
            end else if (!any && (m_idle + 1 == IDLE_LIMIT)) begin
               nf = 0;
            end
         end
         m_elapsed = (nf != m_fld || edited) ? 0 : m_elapsed + 1;
         m_idle    = (nf != m_fld || any) ? 0 : m_idle + 1;
         if (nf == 4) m_load_hms = {8'h00, to_bcd(m_val[1]), to_bcd(m_val[2]), to_bcd(m_val[3])};
         m_fld = nf;
      end
   end

   always @(negedge clk) begin : compare
      chk("run_en",     32'(run_en),     32'(m_fld == 0));
      chk("load",       32'(load),       32'(m_fld == 4));
      chk("load_hms",   load_hms,        m_load_hms);
      chk("edit_field", 32'(edit_field), (m_fld >= 1 && m_fld <= 3) ? 32'(m_fld) : 32'd0);
      chk("blank_mask", 32'(blank_mask), 32'(exp_blank()));
   end

   task automatic tick(input bit md, input bit up, input bit dn);
      btn_mode = md;
      btn_up   = up;
      btn_down = dn;
      @(posedge clk);
      #1;
      btn_mode = 1'b0;
      btn_up   = 1'b0;
      btn_down = 1'b0;
   endtask

   initial begin
      int burst;
      rst = 1'b1;
      tick(0, 0, 0);
      chk("rst_run_en", 32'(run_en), 32'd1);
      chk("rst_load_hms", load_hms, 32'h0);
      tick(0, 0, 0);
      rst = 1'b0;
      tick(0, 0, 0);

      // Capture 23:59:58, edit hour up and minute down twice, commit.
      cur_hms = 32'h00235958;
      tick(1, 0, 0);
      chk("cap_run_en", 32'(run_en), 32'd0);
      chk("cap_field", 32'(edit_field), 32'd1);
      tick(0, 1, 0);
      tick(1, 0, 0);
      tick(0, 0, 1);
      tick(0, 0, 1);
      tick(1, 0, 0);
      tick(1, 0, 0);
      chk("commit_load", 32'(load), 32'd1);
      chk("commit_run_en", 32'(run_en), 32'd0);
      chk("commit_hms", load_hms, 32'h00005758);
      tick(0, 0, 0);
      chk("after_load", 32'(load), 32'd0);
      chk("after_run_en", 32'(run_en), 32'd1);

      // Blink period in SET_M, restarted by an accepted edit.
      cur_hms = 32'h00123456;
      tick(1, 0, 0);
      tick(1, 0, 0);
      chk("blink_enter", 32'(blank_mask), 32'h00);
      for (int k = 1; k <= 14; k++) begin
         tick(0, 0, 0);
         chk("blink_idle", 32'(blank_mask), (k >= 10) ? 32'h0C : 32'h00);
      end
      tick(0, 1, 0);
      chk("blink_edit_clr", 32'(blank_mask), 32'h00);
      for (int k = 1; k <= 10; k++) begin
         tick(0, 0, 0);
         chk("blink_restart", 32'(blank_mask), (k == 10) ? 32'h0C : 32'h00);
      end

      // up+down together ignored; mode+up moves on without editing.
      tick(1, 0, 0);
      tick(0, 1, 1);
      tick(1, 0, 0);
      chk("updown_hms", load_hms, 32'h00123556);
      tick(0, 0, 0);
      tick(1, 0, 0);
      tick(1, 1, 0);
      chk("modeup_field", 32'(edit_field), 32'd2);
      tick(1, 0, 0);
      tick(1, 0, 0);
      chk("modeup_hms", load_hms, 32'h00123456);
      tick(0, 0, 0);

      // Invalid capture and idle timeout.
      cur_hms = 32'h00995A61;
      tick(1, 0, 0);
      for (int k = 1; k < IDLE_LIMIT; k++) tick(0, 0, 0);
      chk("to_pending", 32'(run_en), 32'd0);
      tick(0, 0, 0);
      chk("to_run_en", 32'(run_en), 32'd1);
      chk("to_no_load", 32'(load), 32'd0);
      tick(1, 0, 0);
      tick(1, 0, 0);
      tick(1, 0, 0);
      tick(1, 0, 0);
      chk("invalid_hms", load_hms, 32'h00000000);
      tick(0, 0, 0);

      // Reset mid-edit.
      tick(1, 0, 0);
      tick(1, 0, 0);
      tick(1, 0, 0);
      rst = 1'b1;
      tick(0, 0, 0);
      chk("midrst_run_en", 32'(run_en), 32'd1);
      chk("midrst_field", 32'(edit_field), 32'd0);
      chk("midrst_hms", load_hms, 32'h0);
      rst = 1'b0;
      tick(0, 0, 0);
      chk("midrst_no_load", 32'(load), 32'd0);

      // Randomized traffic with occasional long idle stretches and rare resets.
      burst = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 1) == 0)
            cur_hms = {8'h00, to_bcd(int'($urandom_range(0, 23))),
                       to_bcd(int'($urandom_range(0, 59))), to_bcd(int'($urandom_range(0, 59)))};
         else
            cur_hms = $urandom;
         rst = ($urandom_range(0, 599) == 0);
         if (burst > 0) begin
            burst--;
            tick(0, 0, 0);
         end else begin
            if ($urandom_range(0, 99) < 3) burst = int'($urandom_range(80, 95));
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
         end
      end
      rst = 1'b0;
      tick(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
